inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_perf_counter.sv | 28 ++
 rtl/inst_fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg -- definitions shared by the instruction fetch controller.
// Holds the fetch FSM state type, the default ROM word-address width, the
// default reset PC, and the saturating increment used by the optional
// performance counter.
package fetch_pkg;

  localparam int          ROM_AW_DEFAULT   = 6;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;
  localparam logic [15:0] PERF_MAX         = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Increment that sticks at the maximum value instead of rolling over.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == PERF_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// fetch_perf_counter -- saturating 16-bit event counter.
// Ports:
//   clka  : clock, rising edge
//   rst   : asynchronous active-high reset, clears the count
//   clear : synchronous clear, wins over inc
//   inc   : count one event this cycle
//   count : current count, saturates at 16'hFFFF
module fetch_perf_counter
  import fetch_pkg::*;
(
  input  logic        clka,
  input  logic        rst,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl -- instruction fetch controller in front of a synchronous
// (1-cycle latency) instruction ROM, presenting one instruction per cycle on
// a valid/ready output register.
//
// Parameters:
//   ROM_AW   : ROM word-address width
//   RESET_PC : PC loaded on reset
// Ports:
//   clka                        : clock, rising edge
//   rst                         : asynchronous active-high reset
//   start                       : begin (IDLE) or resume (HALTED) fetching
//   halt                        : stop issuing fetches (FETCH only)
//   redirect_valid, redirect_pc : branch/jump target, byte address (FETCH only)
//   rom_addr                    : ROM word address
//   rom_dout                    : ROM data for the address of the previous cycle
//   inst_valid, inst_ready      : downstream handshake
//   inst_code, inst_pc          : instruction word and its byte address
//   busy                        : FETCH state or an instruction still held
//   fetch_count                 : handshake count (only with FETCH_PERF_EN)
//
// Build option: define FETCH_PERF_EN to add the fetch_count output and its
// saturating handshake counter.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ROM_AW   = ROM_AW_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_dout,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_code,
  output logic [31:0]       inst_pc,
  output logic              busy
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       fetch_count
`endif
);

  fetch_state_e state, state_next;

  // pc is the next address to request; req_pc/req_v describe the request
  // whose data is currently on rom_dout.
  logic [31:0] pc, pc_next;
  logic [31:0] req_pc, req_pc_next;
  logic        req_v, req_v_next;
  logic        inst_valid_next;
  logic [31:0] inst_code_next, inst_pc_next;

  logic slot_free;
  logic handshake;
  logic load;
  logic flush;

  assign slot_free = !inst_valid || inst_ready;
  assign handshake = inst_valid && inst_ready;

  // While stalled the live request is re-read so rom_dout keeps holding the
  // same word; this replaces any skid buffer.
  assign rom_addr = (req_v && !slot_free) ? req_pc[ROM_AW+1:2] : pc[ROM_AW+1:2];

  assign busy = (state == FETCH) || inst_valid;

  // Next-state and datapath decisions. Redirect wins over halt for the pc;
  // halt rewinds pc to the unconsumed request so resume neither loses nor
  // repeats an instruction.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    req_pc_next    = req_pc;
    req_v_next     = req_v;
    inst_code_next = inst_code;
    inst_pc_next   = inst_pc;
    load           = 1'b0;
    flush          = 1'b0;

    case (state)
      IDLE, HALTED: begin
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          req_v_next = 1'b0;
          flush      = 1'b1;
        end else if (halt) begin
          pc_next    = req_v ? req_pc : pc;
          req_v_next = 1'b0;
        end else if (!req_v || slot_free) begin
          req_pc_next = pc;
          pc_next     = pc + 32'd4;
          req_v_next  = 1'b1;
          if (req_v) begin
            load           = 1'b1;
            inst_code_next = rom_dout;
            inst_pc_next   = req_pc;
          end
        end
        if (halt) begin
          state_next = HALTED;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (flush) begin
      inst_valid_next = 1'b0;
    end else if (load) begin
      inst_valid_next = 1'b1;
    end else if (handshake) begin
      inst_valid_next = 1'b0;
    end else begin
      inst_valid_next = inst_valid;
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      req_pc     <= '0;
      req_v      <= 1'b0;
      inst_valid <= 1'b0;
      inst_code  <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      req_pc     <= req_pc_next;
      req_v      <= req_v_next;
      inst_valid <= inst_valid_next;
      inst_code  <= inst_code_next;
      inst_pc    <= inst_pc_next;
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_counter u_perf (
    .clka  (clka),
    .rst   (rst),
    .clear ((state == IDLE) && start),
    .inc   (handshake),
    .count (fetch_count)
  );
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl -- self-checking bench for inst_fetch_ctrl.
// A transaction-level model (pending-fetch queue plus one output slot) is
// updated on every rising edge; a compare process checks all DUT outputs
// against it on every falling edge. Directed sequences add literal checks,
// then randomized start/halt/redirect/ready/reset traffic runs.
// With FETCH_PERF_EN defined, fetch_count is also checked, including its
// saturation after more than 65535 handshakes.
module tb_inst_fetch_ctrl;

  localparam int          ROM_AW   = 6;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic              clka = 1'b0;
  logic              rst;
  logic              start = 1'b0;
  logic              halt = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_dout;
  logic              inst_valid;
  logic              inst_ready = 1'b1;
  logic [31:0]       inst_code;
  logic [31:0]       inst_pc;
  logic              busy;
`ifdef FETCH_PERF_EN
  logic [15:0]       fetch_count;
`endif

  int vector_count = 0;
  int miscompare_count = 0;

  inst_fetch_ctrl #(
    .ROM_AW   (ROM_AW),
    .RESET_PC (RESET_PC)
  ) dut (
    .clka           (clka),
    .rst            (rst),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_dout       (rom_dout),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_code      (inst_code),
    .inst_pc        (inst_pc),
    .busy           (busy)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clka = ~clka;

  // Synchronous ROM: word i holds 0xC0DE_00ii so literal checks are easy.
  logic [31:0] rom [64];
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 | 32'(i);
  end
  always @(posedge clka) rom_dout <= rom[rom_addr];

  // Reference model state.
  typedef enum {M_IDLE, M_FETCH, M_HALTED} model_state_e;
  model_state_e m_state = M_IDLE;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] inflight[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_code = 32'h0;
  logic [31:0] m_inst_pc = 32'h0;
  logic [15:0] m_count = 16'h0;
  logic        m_handshake, m_room, m_loaded, m_flushed;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miscompare_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: at most one fetch is in flight; it moves to the output slot when
  // the slot frees, and every cycle of progress issues the next sequential pc.
  initial forever begin
    @(posedge clka or posedge rst);
    if (rst) begin
      m_state   = M_IDLE;
      m_pc      = RESET_PC;
      inflight.delete();
      m_valid   = 1'b0;
      m_code    = 32'h0;
      m_inst_pc = 32'h0;
      m_count   = 16'h0;
    end else begin
      m_handshake = m_valid && inst_ready;
      m_room      = !m_valid || inst_ready;
      m_loaded    = 1'b0;
      m_flushed   = 1'b0;
      case (m_state)
        M_IDLE: if (start) begin m_state = M_FETCH; m_count = 16'h0; end
        M_HALTED: if (start) m_state = M_FETCH;
        default: begin
          if (redirect_valid) begin
            m_pc = redirect_pc;
            inflight.delete();
            m_flushed = 1'b1;
          end else if (halt) begin
            if (inflight.size() != 0) m_pc = inflight[0];
            inflight.delete();
          end else if (inflight.size() == 0 || m_room) begin
            if (inflight.size() != 0) begin
              m_inst_pc = inflight.pop_front();
              m_code    = rom[m_inst_pc[7:2]];
              m_loaded  = 1'b1;
            end
            inflight.push_back(m_pc);
            m_pc = m_pc + 32'd4;
          end
          if (halt) m_state = M_HALTED;
        end
      endcase
      if (m_handshake && m_count != 16'hFFFF) m_count = m_count + 16'd1;
      if (m_flushed) m_valid = 1'b0;
      else if (m_loaded) m_valid = 1'b1;
      else if (m_handshake) m_valid = 1'b0;
    end
  end

  // Compare every cycle, mid-way between rising edges.
  initial forever begin
    logic [31:0] exp_addr_pc;
    @(negedge clka);
    exp_addr_pc = m_pc;
    if (inflight.size() != 0 && m_valid && !inst_ready) exp_addr_pc = inflight[0];
    checkOutput("cmp_rom_addr", {26'h0, rom_addr}, {26'h0, exp_addr_pc[7:2]});
    checkOutput("cmp_inst_valid", {31'h0, inst_valid}, {31'h0, m_valid});
    checkOutput("cmp_inst_pc", inst_pc, m_inst_pc);
    checkOutput("cmp_inst_code", inst_code, m_code);
    checkOutput("cmp_busy", {31'h0, busy}, {31'h0, (m_state == M_FETCH) || m_valid});
`ifdef FETCH_PERF_EN
    checkOutput("cmp_fetch_count", {16'h0, fetch_count}, {16'h0, m_count});
`endif
  end

  task automatic cyc();
    @(negedge clka);
    #1;
  endtask

  task automatic applyStimulus();
    int sel;
    if (rst) rst = 1'b0;
    else rst = ($urandom_range(0, 499) == 0);
    inst_ready     = ($urandom_range(0, 9) < 7);
    start          = ($urandom_range(0, 19) == 0);
    halt           = ($urandom_range(0, 29) == 0);
    redirect_valid = ($urandom_range(0, 24) == 0);
    sel = $urandom_range(0, 3);
    if (sel == 0) redirect_pc = $urandom;
    else if (sel == 1) redirect_pc = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
    else redirect_pc = 32'($urandom_range(0, 63)) << 2;
  endtask

  initial begin
    $display("[TB] inst_fetch_ctrl bench starting");
    rst = 1'b1;
    cyc();
    checkOutput("reset_valid", {31'h0, inst_valid}, 32'h0);
    checkOutput("reset_pc", inst_pc, 32'h0);
    checkOutput("reset_code", inst_code, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h0);
    checkOutput("reset_rom_addr", {26'h0, rom_addr}, 32'h0);
    rst = 1'b0;
    cyc();

    // Straight-line fetch from reset: first valid three cycles after start.
    start = 1'b1; cyc(); start = 1'b0; cyc();
    checkOutput("first_not_early", {31'h0, inst_valid}, 32'h0);
    cyc();
    checkOutput("first_valid", {31'h0, inst_valid}, 32'h1);
    checkOutput("first_pc", inst_pc, 32'h0);
    checkOutput("first_code", inst_code, 32'hC0DE_0000);
    cyc();
    checkOutput("second_pc", inst_pc, 32'h4);
    checkOutput("second_code", inst_code, 32'hC0DE_0001);
    cyc();
    checkOutput("third_pc", inst_pc, 32'h8);
    checkOutput("third_code", inst_code, 32'hC0DE_0002);

    // Back-pressure for four cycles while 0x8 is presented.
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checkOutput("stall_pc", inst_pc, 32'h8);
      checkOutput("stall_code", inst_code, 32'hC0DE_0002);
      checkOutput("stall_rom_addr", {26'h0, rom_addr}, 32'h3);
    end
    inst_ready = 1'b1;
    cyc();
    checkOutput("after_stall_pc", inst_pc, 32'hC);
    checkOutput("after_stall_code", inst_code, 32'hC0DE_0003);
    cyc();
    checkOutput("after_stall_pc2", inst_pc, 32'h10);

    // Redirect to 0x40 while 0x10 is valid.
    redirect_valid = 1'b1; redirect_pc = 32'h40; cyc(); redirect_valid = 1'b0;
    checkOutput("redirect_flush", {31'h0, inst_valid}, 32'h0);
    cyc();
    checkOutput("redirect_gap", {31'h0, inst_valid}, 32'h0);
    cyc();
    checkOutput("redirect_valid", {31'h0, inst_valid}, 32'h1);
    checkOutput("redirect_pc", inst_pc, 32'h40);
    checkOutput("redirect_code", inst_code, 32'hC0DE_0010);

    // Reposition to 0x14, then halt as 0x14 is accepted.
    redirect_valid = 1'b1; redirect_pc = 32'h14; cyc(); redirect_valid = 1'b0;
    cyc(); cyc();
    checkOutput("pre_halt_pc", inst_pc, 32'h14);
    halt = 1'b1; cyc(); halt = 1'b0;
    checkOutput("halt_drained", {31'h0, inst_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      checkOutput("halted_busy", {31'h0, busy}, 32'h0);
    end
    start = 1'b1; cyc(); start = 1'b0; cyc();
    checkOutput("resume_not_early", {31'h0, inst_valid}, 32'h0);
    cyc();
    checkOutput("resume_pc", inst_pc, 32'h18);
    cyc();
    checkOutput("resume_next_pc", inst_pc, 32'h1C);

    // ROM address wrap: 0xF8, 0xFC, then 0x100 reads word 0.
    redirect_valid = 1'b1; redirect_pc = 32'hF8; cyc(); redirect_valid = 1'b0;
    checkOutput("wrap_addr62", {26'h0, rom_addr}, 32'd62);
    cyc();
    checkOutput("wrap_addr63", {26'h0, rom_addr}, 32'd63);
    cyc();
    checkOutput("wrap_addr0", {26'h0, rom_addr}, 32'd0);
    checkOutput("wrap_pc_f8", inst_pc, 32'hF8);
    cyc();
    checkOutput("wrap_code_fc", inst_code, 32'hC0DE_003F);
    cyc();
    checkOutput("wrap_pc_100", inst_pc, 32'h100);
    checkOutput("wrap_code_100", inst_code, 32'hC0DE_0000);

    // Asynchronous reset in the middle of a stall.
    inst_ready = 1'b0;
    cyc();
    checkOutput("pre_reset_valid", {31'h0, inst_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'h0, inst_valid}, 32'h0);
    checkOutput("async_rst_code", inst_code, 32'h0);
    checkOutput("async_rst_pc", inst_pc, 32'h0);
    checkOutput("async_rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("async_rst_rom_addr", {26'h0, rom_addr}, 32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("async_rst_count", {16'h0, fetch_count}, 32'h0);
`endif
    cyc();
    rst = 1'b0;
    inst_ready = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      applyStimulus();
    end

`ifdef FETCH_PERF_EN
    // Long run to saturate the handshake counter.
    cyc();
    rst = 1'b1; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 70010; i++) cyc();
    checkOutput("fetch_count_sat", {16'h0, fetch_count}, 32'h0000_FFFF);
`endif

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
    $finish;
  end

endmodule
